seq_mag_compare: RTL and testbench
==================================

# seq_mag_compare

Multi-cycle, parametrised magnitude comparator. It compares two WIDTH-bit operands MSB-first, SLICE bits per clock, and terminates early on the first unequal slice. It supports unsigned and two's-complement modes and keeps the classic cascade inputs for chaining. It is the sequential successor to the calculator's combinational 4-bit/8-bit comparators and feeds the ALU's compare/branch logic with a start/done handshake.

## Interface
- WIDTH, 16: operand width in bits; must be a multiple of SLICE.
- SLICE, 4: bits examined per COMPARE cycle. SLICE = WIDTH gives a single-cycle compare.
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when busy = 0.
- a  input  WIDTH  operand A; sampled on the accepting edge only.
- b  input  WIDTH  operand B; sampled on the accepting edge only.
- signed_mode  input  1  1 = two's-complement compare; sampled with the operands.
- alb_in, agb_in, aeb_in  input  1 each  cascade inputs from a less-significant stage; sampled with the operands.
- busy  output  1  high while in COMPARE.
- done  output  1  one-cycle pulse when the result is valid.
- alb, agb, aeb  output  1 each  registered result; held until the next completion or reset.

## Operation
- N = WIDTH/SLICE slices. Slice index k runs from N-1 (most significant) down to 0.
- States:
  - IDLE: wait for start; go to COMPARE when start is accepted.
  - COMPARE: examine slice k. If the slice is unequal, or k = 0, go to DONE. Otherwise decrement k and stay in COMPARE.
  - DONE: go to IDLE, or straight to COMPARE if start = 1 in this cycle.
- Start acceptance:
  - start is accepted in IDLE or DONE.
  - On acceptance: capture a, b, signed_mode and the cascade inputs; set k = N-1.
  - start while busy = 1 is ignored. Captured operands do not change mid-compare.
- Slice compare is unsigned on the slice bits. When signed_mode = 1, bit WIDTH-1 of both captured operands is inverted before the compare of slice N-1 only.
- First unequal slice decides the result:
  - A slice > B slice: agb = 1, alb = 0, aeb = 0.
  - A slice < B slice: alb = 1, agb = 0, aeb = 0.
- All slices equal, cascade resolution (74x85 semantics):
  - aeb = aeb_in.
  - agb = !alb_in & !aeb_in.
  - alb = !agb_in & !aeb_in.
  - Consequences: aeb_in = 1 gives 0/0/1. Cascade inputs all 0 gives alb = agb = 1. Both alb_in and agb_in high gives all outputs 0.
- Results register on the edge entering DONE.

## Timing
- Reset values: state = IDLE, k = N-1, busy = 0, done = 0, alb = agb = aeb = 0, captured operand registers = 0.
- Latency: start is accepted at edge 0. With the decision at slice index j, the compare examines m = N-j slices (1..N). done is high in cycle m+1 after edge 0.
  - Best case: 2 cycles.
  - Worst case (operands equal): N+1 cycles.
- Throughput: with start held high, a new operation starts in the DONE cycle, giving one result every m+1 cycles.
- busy is high in exactly the m COMPARE cycles.
- done is high for exactly one cycle. alb/agb/aeb change only on the edge that raises done.
- Reset mid-operation: abort immediately with no done pulse. All outputs return to reset values on the next edge. rst has priority over start.
- SLICE = WIDTH: every operation takes exactly one COMPARE cycle.

## Structure
- Package mag_cmp_pkg holds:
  - the state enum (IDLE, COMPARE, DONE);
  - the 2-bit slice-result encoding (EQ, LT, GT);
  - a function that resolves an all-equal compare through the cascade inputs.
- Sub-module slice_compare: combinational SLICE-bit compare producing lt/gt/eq. It has a single instance in seq_mag_compare, fed by a slice mux indexed by k.
- k counter width: $clog2(N), minimum 1 bit.

## Test plan
All scenarios use WIDTH = 16, SLICE = 4 unless stated.
- a = 0x9234, b = 0x1234, unsigned, aeb_in = 1 → done in cycle 2; agb = 1, alb = 0, aeb = 0; busy high for 1 cycle.
- a = 0x1234, b = 0x1234, aeb_in = 1 → done in cycle 5; aeb = 1, others 0. Repeat with all cascade inputs 0 → alb = agb = 1, aeb = 0.
- a = 0x8000, b = 0x0001: signed_mode = 1 → alb = 1, done in cycle 2. signed_mode = 0 → agb = 1.
- a = 0x1230, b = 0x1231 with start held high → alb = 1 at cycle 5. Change a/b while busy → result unaffected. Next operation begins at the DONE cycle.
- Assert rst in the 3rd COMPARE cycle → no done pulse; busy, done and alb/agb/aeb all 0 next cycle. Next start completes normally.
- WIDTH = 8, SLICE = 8: a = 0x05, b = 0x07 → alb = 1, done in cycle 2, busy high for 1 cycle.

Source files
------------

// File: rtl/mag_cmp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
// Holds the FSM state, the slice-result encoding and the cascade resolution.
package mag_cmp_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCompare = 2'd1,
    StDone    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CmpEq = 2'b00,
    CmpLt = 2'b01,
    CmpGt = 2'b10
  } cmp_e;

  typedef struct packed {
    logic alb;
    logic agb;
    logic aeb;
  } cmp_res_t;

  // 74x85-style resolution when every slice compared equal.
  function automatic cmp_res_t cascade_resolve(input logic alb_in, input logic agb_in,
                                               input logic aeb_in);
    cmp_res_t r;
    r.aeb = aeb_in;
    r.agb = !alb_in && !aeb_in;
    r.alb = !agb_in && !aeb_in;
    return r;
  endfunction

  function automatic cmp_res_t decided_result(input cmp_e c);
    cmp_res_t r;
    r.alb = (c == CmpLt);
    r.agb = (c == CmpGt);
    r.aeb = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/slice_compare.sv
// Combinational unsigned compare of one SLICE-bit operand slice.
module slice_compare #(
  parameter int unsigned SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  always_comb begin
    lt = (a < b);
    gt = (a > b);
    eq = (a == b);
  end

endmodule

// File: rtl/seq_mag_compare.sv
// Multi-cycle MSB-first magnitude comparator with early exit on the first unequal
// slice, optional two's-complement mode and 74x85-style cascade inputs.
module seq_mag_compare
  import mag_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             alb_in,
  input  logic             agb_in,
  input  logic             aeb_in,
  output logic             busy,
  output logic             done,
  output logic             alb,
  output logic             agb,
  output logic             aeb
);

  localparam int unsigned N  = WIDTH / SLICE;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KMax = KW'(N - 1);

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             signed_q, signed_d;
  cmp_res_t         casc_q, casc_d;
  cmp_res_t         res_q, res_d;

  logic [SLICE-1:0] a_sl, b_sl;
  logic             sl_lt, sl_gt, sl_eq;
  cmp_e             slice_cmp;
  logic             accept;

  // Slice mux; in signed mode the sign bits are flipped only on the top slice.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        a_sl = a_q[i*SLICE +: SLICE];
        b_sl = b_q[i*SLICE +: SLICE];
      end
    end
    if (signed_q && (k_q == KMax)) begin
      a_sl[SLICE-1] = ~a_sl[SLICE-1];
      b_sl[SLICE-1] = ~b_sl[SLICE-1];
    end
  end

  slice_compare #(
    .SLICE(SLICE)
  ) u_slice_compare (
    .a  (a_sl),
    .b  (b_sl),
    .lt (sl_lt),
    .gt (sl_gt),
    .eq (sl_eq)
  );

  always_comb begin
    if (sl_gt)      slice_cmp = CmpGt;
    else if (sl_lt) slice_cmp = CmpLt;
    else            slice_cmp = CmpEq;
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    casc_d   = casc_q;
    res_d    = res_q;
    accept   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) accept = 1'b1;
      end
      StCompare: begin
        if (!sl_eq || (k_q == '0)) begin
          state_d = StDone;
          if (slice_cmp == CmpEq) begin
            res_d = cascade_resolve(casc_q.alb, casc_q.agb, casc_q.aeb);
          end else begin
            res_d = decided_result(slice_cmp);
          end
        end else begin
          k_d = k_q - 1'b1;
        end
      end
      StDone: begin
        if (start) accept = 1'b1;
        else       state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      state_d    = StCompare;
      k_d        = KMax;
      a_d        = a;
      b_d        = b;
      signed_d   = signed_mode;
      casc_d.alb = alb_in;
      casc_d.agb = agb_in;
      casc_d.aeb = aeb_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      k_q      <= KMax;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      casc_q   <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      casc_q   <= casc_d;
      res_q    <= res_d;
    end
  end

  always_comb begin
    busy = (state_q == StCompare);
    done = (state_q == StDone);
    alb  = res_q.alb;
    agb  = res_q.agb;
    aeb  = res_q.aeb;
  end

endmodule

// File: tb/tb_seq_mag_compare.sv
// Directed self-checking bench for seq_mag_compare (16/4 and 8/8 configurations).
module tb_seq_mag_compare;

  logic        clk = 1'b0;
  logic        rst, start, start8;
  logic [15:0] a, b;
  logic [7:0]  a8, b8;
  logic        sm, sm8, alb_in, agb_in, aeb_in;
  logic        busy, done, alb, agb, aeb;
  logic        busy8, done8, alb8, agb8, aeb8;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  seq_mag_compare #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .signed_mode(sm),
    .alb_in(alb_in), .agb_in(agb_in), .aeb_in(aeb_in),
    .busy(busy), .done(done), .alb(alb), .agb(agb), .aeb(aeb)
  );

  seq_mag_compare #(.WIDTH(8), .SLICE(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .signed_mode(sm8),
    .alb_in(alb_in), .agb_in(agb_in), .aeb_in(aeb_in),
    .busy(busy8), .done(done8), .alb(alb8), .agb(agb8), .aeb(aeb8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and measure the cycle done rises in (-1 if never) and busy cycles.
  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic smv,
                       input logic li, input logic gi, input logic ei,
                       output int lat, output int busy_cnt);
    a = av; b = bv; sm = smv; alb_in = li; agb_in = gi; aeb_in = ei;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    busy_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      if (busy) busy_cnt++;
      tick();
    end
  endtask

  task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input logic smv,
                        output int lat, output int busy_cnt);
    a8 = av; b8 = bv; sm8 = smv; alb_in = 1'b0; agb_in = 1'b0; aeb_in = 1'b1;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = -1;
    busy_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      if (done8) begin
        lat = c;
        break;
      end
      if (busy8) busy_cnt++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start8 = 1'b0;
    a = '0; b = '0; a8 = '0; b8 = '0; sm = 1'b0; sm8 = 1'b0;
    alb_in = 1'b0; agb_in = 1'b0; aeb_in = 1'b0;
    tick(); tick();
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    total++;
    if ({alb, agb, aeb} !== 3'b000)
      $display("FAIL reset_result: got %b want 000", {alb, agb, aeb});
    else passed++;
    total++;
    if ({busy8, done8, alb8, agb8, aeb8} !== 5'b0)
      $display("FAIL reset_dut8: got %b want 00000", {busy8, done8, alb8, agb8, aeb8});
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unsigned_early();
    int lat, bc;
    do_op(16'h9234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, lat, bc);
    total++;
    if (lat !== 2) $display("FAIL early_latency: got %0d want 2", lat); else passed++;
    total++;
    if (bc !== 1) $display("FAIL early_busy: got %0d want 1", bc); else passed++;
    total++;
    if ({alb, agb, aeb} !== 3'b010)
      $display("FAIL early_result: got %b want 010", {alb, agb, aeb});
    else passed++;
  endtask

  task automatic test_equal_cascade();
    int lat, bc;
    do_op(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, lat, bc);
    total++;
    if (lat !== 5) $display("FAIL equal_latency: got %0d want 5", lat); else passed++;
    total++;
    if (bc !== 4) $display("FAIL equal_busy: got %0d want 4", bc); else passed++;
    total++;
    if ({alb, agb, aeb} !== 3'b001)
      $display("FAIL equal_aeb_in: got %b want 001", {alb, agb, aeb});
    else passed++;
    do_op(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, lat, bc);
    total++;
    if ({alb, agb, aeb} !== 3'b110)
      $display("FAIL equal_casc_zero: got %b want 110", {alb, agb, aeb});
    else passed++;
    do_op(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b0, lat, bc);
    total++;
    if ({alb, agb, aeb} !== 3'b000)
      $display("FAIL equal_casc_ltgt: got %b want 000", {alb, agb, aeb});
    else passed++;
  endtask

  task automatic test_signed();
    int lat, bc;
    do_op(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, lat, bc);
    total++;
    if (lat !== 2) $display("FAIL signed_latency: got %0d want 2", lat); else passed++;
    total++;
    if ({alb, agb, aeb} !== 3'b100)
      $display("FAIL signed_neg_lt_pos: got %b want 100", {alb, agb, aeb});
    else passed++;
    do_op(16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, lat, bc);
    total++;
    if ({alb, agb, aeb} !== 3'b010)
      $display("FAIL unsigned_8000_gt: got %b want 010", {alb, agb, aeb});
    else passed++;
    do_op(16'hFFFF, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1, lat, bc);
    total++;
    if (lat !== 5) $display("FAIL signed_low_latency: got %0d want 5", lat); else passed++;
    total++;
    if ({alb, agb, aeb} !== 3'b010)
      $display("FAIL signed_m1_gt_m2: got %b want 010", {alb, agb, aeb});
    else passed++;
  endtask

  task automatic test_back_to_back();
    int lat;
    a = 16'h1230; b = 16'h1231; sm = 1'b0;
    alb_in = 1'b0; agb_in = 1'b0; aeb_in = 1'b1;
    start = 1'b1;
    tick();
    // Operands change mid-compare; the next capture happens only in the DONE cycle.
    a = 16'hFFFF; b = 16'h0000;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      tick();
    end
    total++;
    if (lat !== 5) $display("FAIL b2b_latency: got %0d want 5", lat); else passed++;
    total++;
    if ({alb, agb, aeb} !== 3'b100)
      $display("FAIL b2b_first_result: got %b want 100", {alb, agb, aeb});
    else passed++;
    tick();
    start = 1'b0;
    total++;
    if ({busy, done} !== 2'b10)
      $display("FAIL b2b_restart: got busy/done %b want 10", {busy, done});
    else passed++;
    tick();
    total++;
    if (done !== 1'b1) $display("FAIL b2b_second_done: got %b want 1", done); else passed++;
    total++;
    if ({alb, agb, aeb} !== 3'b010)
      $display("FAIL b2b_second_result: got %b want 010", {alb, agb, aeb});
    else passed++;
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    logic seen;
    a = 16'h1234; b = 16'h1234; sm = 1'b0;
    alb_in = 1'b0; agb_in = 1'b0; aeb_in = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    total++;
    if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", busy); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({busy, done, alb, agb, aeb} !== 5'b0)
      $display("FAIL rstmid_cleared: got %b want 00000", {busy, done, alb, agb, aeb});
    else passed++;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (done) seen = 1'b1;
      tick();
    end
    total++;
    if (seen !== 1'b0) $display("FAIL rstmid_no_done: got %b want 0", seen); else passed++;
    do_op(16'h0005, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b1, lat, bc);
    total++;
    if (lat !== 5) $display("FAIL rstmid_next_latency: got %0d want 5", lat); else passed++;
    total++;
    if ({alb, agb, aeb} !== 3'b100)
      $display("FAIL rstmid_next_result: got %b want 100", {alb, agb, aeb});
    else passed++;
  endtask

  task automatic test_single_slice();
    int lat, bc;
    do_op8(8'h05, 8'h07, 1'b0, lat, bc);
    total++;
    if (lat !== 2) $display("FAIL w8_latency: got %0d want 2", lat); else passed++;
    total++;
    if (bc !== 1) $display("FAIL w8_busy: got %0d want 1", bc); else passed++;
    total++;
    if ({alb8, agb8, aeb8} !== 3'b100)
      $display("FAIL w8_result: got %b want 100", {alb8, agb8, aeb8});
    else passed++;
    do_op8(8'h80, 8'h01, 1'b1, lat, bc);
    total++;
    if ({alb8, agb8, aeb8} !== 3'b100)
      $display("FAIL w8_signed: got %b want 100", {alb8, agb8, aeb8});
    else passed++;
    do_op8(8'h80, 8'h01, 1'b0, lat, bc);
    total++;
    if ({alb8, agb8, aeb8} !== 3'b010)
      $display("FAIL w8_unsigned: got %b want 010", {alb8, agb8, aeb8});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_unsigned_early();
    test_equal_cascade();
    test_signed();
    test_back_to_back();
    test_reset_mid();
    test_single_slice();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
